// File: rtl/pic_alu_pkg.sv
// Shared definitions for the PIC-style ALU datapath: opcode encoding,
// operand-select codes and the default datapath width.
package pic_alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Operand select values seen on switch_a_m
    localparam logic OPSEL_FILE = 1'b0;
    localparam logic OPSEL_LIT  = 1'b1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_IOR  = 4'h3,
        OP_XOR  = 4'h4,
        OP_COM  = 4'h5,
        OP_INC  = 4'h6,
        OP_DEC  = 4'h7,
        OP_MOVF = 4'h8,
        OP_MOVW = 4'h9,
        OP_RLF  = 4'hA,
        OP_RRF  = 4'hB,
        OP_SWAP = 4'hC,
        OP_BCF  = 4'hD,
        OP_BSF  = 4'hE,
        OP_CLR  = 4'hF
    } alu_op_e;

endpackage

// File: rtl/pic_alu_core.sv
// Combinational ALU for the PIC-style datapath. Produces the result, the
// candidate carry and flags telling the top which status bits to update.
// Optional macro ALU_DIGIT_CARRY_EN adds the digit-carry (bit 3) path.
import pic_alu_pkg::*;

module pic_alu_core #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       bit_number,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic             carry_next,
    output logic             carry_upd,
    output logic             zero_upd
`ifdef ALU_DIGIT_CARRY_EN
    ,
    input  logic             dc_in,
    output logic             dc_next
`endif
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] mask;

    // Extra top bit of sum is the carry; top bit of diff is the borrow
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, b} - {1'b0, a};
    assign mask = ONE << bit_number;

    // Opcode decode: result plus which status bits this opcode touches
    always_comb begin
        result     = '0;
        carry_next = carry_in;
        carry_upd  = 1'b0;
        zero_upd   = 1'b1;
        case (alu_op_e'(op))
            OP_ADD: begin
                result     = sum[WIDTH-1:0];
                carry_next = sum[WIDTH];
                carry_upd  = 1'b1;
            end
            OP_SUB: begin
                result     = diff[WIDTH-1:0];
                carry_next = ~diff[WIDTH];
                carry_upd  = 1'b1;
            end
            OP_AND:  result = a & b;
            OP_IOR:  result = a | b;
            OP_XOR:  result = a ^ b;
            OP_COM:  result = ~b;
            OP_INC:  result = b + ONE;
            OP_DEC:  result = b - ONE;
            OP_MOVF: result = b;
            OP_MOVW: result = a;
            OP_RLF: begin
                result     = {b[WIDTH-2:0], carry_in};
                carry_next = b[WIDTH-1];
                carry_upd  = 1'b1;
            end
            OP_RRF: begin
                result     = {carry_in, b[WIDTH-1:1]};
                carry_next = b[0];
                carry_upd  = 1'b1;
            end
            OP_SWAP: begin
                result   = {b[WIDTH/2-1:0], b[WIDTH-1:WIDTH/2]};
                zero_upd = 1'b0;
            end
            OP_BCF: begin
                result   = b & ~mask;
                zero_upd = 1'b0;
            end
            OP_BSF: begin
                result   = b | mask;
                zero_upd = 1'b0;
            end
            OP_CLR:  result = '0;
            default: result = '0;
        endcase
    end

`ifdef ALU_DIGIT_CARRY_EN
    logic [4:0] nib_sum;
    logic [4:0] nib_diff;

    assign nib_sum  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    assign nib_diff = {1'b0, b[3:0]} - {1'b0, a[3:0]};

    // Digit carry follows ADD/SUB only; all other opcodes pass the old value
    always_comb begin
        dc_next = dc_in;
        if (alu_op_e'(op) == OP_ADD)
            dc_next = nib_sum[4];
        else if (alu_op_e'(op) == OP_SUB)
            dc_next = ~nib_diff[4];
    end
`endif

endmodule

// File: rtl/pic_alu_datapath.sv
// Execution datapath of the PIC-style core: operand mux, ALU, status
// registers, file write strobe and registered data bus buffer.
// Optional macro ALU_DIGIT_CARRY_EN adds the dc (digit carry) output.
import pic_alu_pkg::*;

module pic_alu_datapath #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       inst,
    input  logic [2:0]       bit_number,
    input  logic             switch_a_m,
    input  logic             dest,
    input  logic             bus_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ans,
    output logic             carry,
    output logic             zero,
    output logic             write_en,
    output logic [WIDTH-1:0] data_bus_out,
    output logic             data_bus_oe
`ifdef ALU_DIGIT_CARRY_EN
    ,
    output logic             dc
`endif
);

    logic [WIDTH-1:0] result;
    logic             carry_next;
    logic             carry_upd;
    logic             zero_upd;
`ifdef ALU_DIGIT_CARRY_EN
    logic             dc_next;
`endif

    // Operand select between file value and instruction literal
    always_comb begin
        b = f;
        case (switch_a_m)
            OPSEL_FILE: b = f;
            OPSEL_LIT:  b = k;
            default:    b = f;
        endcase
    end

    pic_alu_core #(.WIDTH(WIDTH)) u_core (
        .op         (inst),
        .a          (a),
        .b          (b),
        .bit_number (bit_number),
        .carry_in   (carry),
        .result     (result),
        .carry_next (carry_next),
        .carry_upd  (carry_upd),
        .zero_upd   (zero_upd)
`ifdef ALU_DIGIT_CARRY_EN
        ,
        .dc_in      (dc),
        .dc_next    (dc_next)
`endif
    );

    // Result and status registers; carry/zero only move when the opcode owns them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ans      <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            write_en <= 1'b0;
        end else begin
            write_en <= op_valid & dest;
            if (op_valid) begin
                ans <= result;
                if (carry_upd)
                    carry <= carry_next;
                if (zero_upd)
                    zero <= (result == '0);
            end
        end
    end

    // Bus buffer samples ans before this edge's update, so it trails ans by a cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_bus_oe  <= 1'b0;
            data_bus_out <= '0;
        end else begin
            data_bus_oe  <= bus_en;
            data_bus_out <= bus_en ? ans : '0;
        end
    end

`ifdef ALU_DIGIT_CARRY_EN
    // Digit carry register, loaded only when an operation executes
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dc <= 1'b0;
        else if (op_valid)
            dc <= dc_next;
    end
`endif

endmodule

// File: tb/tb_pic_alu_datapath.sv
// Self-checking bench for pic_alu_datapath: vector table driven through a
// scoreboard queue, plus hand-written reset and bus sequences.
module tb_pic_alu_datapath;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       op_valid;
    logic [3:0] inst;
    logic [2:0] bit_number;
    logic       switch_a_m;
    logic       dest;
    logic       bus_en;
    logic [7:0] a, f, k;
    logic [7:0] b, ans, data_bus_out;
    logic       carry, zero, write_en, data_bus_oe;
`ifdef ALU_DIGIT_CARRY_EN
    logic       dc;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       ov;
        logic [3:0] inst;
        logic [2:0] bn;
        logic       sw;
        logic       dest;
        logic       be;
        logic [7:0] a;
        logic [7:0] f;
        logic [7:0] k;
        logic [7:0] ans;
        logic       c;
        logic       z;
        logic       we;
        logic       oe;
        logic [7:0] bo;
    } vec_t;

    vec_t vecs[23];
    vec_t sb[$];

    pic_alu_datapath #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .inst         (inst),
        .bit_number   (bit_number),
        .switch_a_m   (switch_a_m),
        .dest         (dest),
        .bus_en       (bus_en),
        .a            (a),
        .f            (f),
        .k            (k),
        .b            (b),
        .ans          (ans),
        .carry        (carry),
        .zero         (zero),
        .write_en     (write_en),
        .data_bus_out (data_bus_out),
        .data_bus_oe  (data_bus_oe)
`ifdef ALU_DIGIT_CARRY_EN
        ,
        .dc           (dc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk8({tag, ".ans"}, ans, 8'h00);
        chk1({tag, ".carry"}, carry, L);
        chk1({tag, ".zero"}, zero, L);
        chk1({tag, ".write_en"}, write_en, L);
        chk1({tag, ".oe"}, data_bus_oe, L);
        chk8({tag, ".bus"}, data_bus_out, 8'h00);
    endtask

    // Drive one vector, push its expectation, then pop and compare after the edge
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        op_valid   = v.ov;
        inst       = v.inst;
        bit_number = v.bn;
        switch_a_m = v.sw;
        dest       = v.dest;
        bus_en     = v.be;
        a          = v.a;
        f          = v.f;
        k          = v.k;
        #1;
        chk8({tag, ".b"}, b, v.sw ? v.k : v.f);
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.scoreboard: got empty queue want 1 entry", tag);
        end else begin
            e = sb.pop_front();
            chk8({tag, ".ans"}, ans, e.ans);
            chk1({tag, ".carry"}, carry, e.c);
            chk1({tag, ".zero"}, zero, e.z);
            chk1({tag, ".write_en"}, write_en, e.we);
            chk1({tag, ".oe"}, data_bus_oe, e.oe);
            chk8({tag, ".bus"}, data_bus_out, e.bo);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        //           ov inst  bn    sw dest be  a      f      k       ans    c  z  we oe bo
        vecs[0]  = '{H, 4'h0, 3'd0, L, H, L, 8'hF0, 8'h20, 8'h00, 8'h10, H, L, H, L, 8'h00}; // ADD overflow
        vecs[1]  = '{L, 4'h0, 3'd0, L, H, L, 8'h00, 8'h00, 8'h00, 8'h10, H, L, L, L, 8'h00}; // idle, strobe drops
        vecs[2]  = '{H, 4'h1, 3'd0, H, L, L, 8'h05, 8'h77, 8'h05, 8'h00, H, H, L, L, 8'h00}; // SUB literal equal
        vecs[3]  = '{H, 4'h1, 3'd0, H, L, L, 8'h06, 8'h77, 8'h05, 8'hFF, L, L, L, L, 8'h00}; // SUB borrow
        vecs[4]  = '{H, 4'h2, 3'd0, L, L, L, 8'hF0, 8'h3C, 8'h00, 8'h30, L, L, L, L, 8'h00}; // AND
        vecs[5]  = '{H, 4'h3, 3'd0, L, H, L, 8'hF0, 8'h3C, 8'h00, 8'hFC, L, L, H, L, 8'h00}; // IOR
        vecs[6]  = '{H, 4'h4, 3'd0, L, H, L, 8'hF0, 8'h3C, 8'h00, 8'hCC, L, L, H, L, 8'h00}; // XOR back-to-back write
        vecs[7]  = '{H, 4'h5, 3'd0, L, L, L, 8'h00, 8'h0F, 8'h00, 8'hF0, L, L, L, L, 8'h00}; // COM
        vecs[8]  = '{H, 4'h7, 3'd0, L, L, L, 8'h00, 8'h00, 8'h00, 8'hFF, L, L, L, L, 8'h00}; // DEC wrap
        vecs[9]  = '{H, 4'h0, 3'd0, L, L, L, 8'hFF, 8'h01, 8'h00, 8'h00, H, H, L, L, 8'h00}; // ADD to zero
        vecs[10] = '{H, 4'hA, 3'd0, L, L, L, 8'h00, 8'h80, 8'h00, 8'h01, H, L, L, L, 8'h00}; // RLF
        vecs[11] = '{H, 4'hB, 3'd0, L, L, L, 8'h00, 8'h01, 8'h00, 8'h80, H, L, L, L, 8'h00}; // RRF
        vecs[12] = '{H, 4'hF, 3'd0, L, L, L, 8'h12, 8'h34, 8'h00, 8'h00, H, H, L, L, 8'h00}; // CLR
        vecs[13] = '{H, 4'hE, 3'd7, L, L, L, 8'h00, 8'h00, 8'h00, 8'h80, H, H, L, L, 8'h00}; // BSF, zero held
        vecs[14] = '{H, 4'hD, 3'd0, L, L, L, 8'h00, 8'hFF, 8'h00, 8'hFE, H, H, L, L, 8'h00}; // BCF
        vecs[15] = '{H, 4'hC, 3'd0, L, L, L, 8'h00, 8'hA5, 8'h00, 8'h5A, H, H, L, L, 8'h00}; // SWAP
        vecs[16] = '{H, 4'h9, 3'd0, L, L, L, 8'h00, 8'hFF, 8'h00, 8'h00, H, H, L, L, 8'h00}; // MOVW
        vecs[17] = '{H, 4'h8, 3'd0, L, L, L, 8'h00, 8'h3C, 8'h00, 8'h3C, H, L, L, L, 8'h00}; // MOVF
        vecs[18] = '{L, 4'h0, 3'd0, L, L, H, 8'h00, 8'h00, 8'h00, 8'h3C, H, L, L, H, 8'h3C}; // bus drive
        vecs[19] = '{L, 4'h0, 3'd0, L, L, L, 8'h00, 8'h00, 8'h00, 8'h3C, H, L, L, L, 8'h00}; // bus release
        vecs[20] = '{H, 4'h6, 3'd0, L, L, H, 8'h00, 8'hFF, 8'h00, 8'h00, H, H, L, H, 8'h3C}; // INC wrap + old ans on bus
        vecs[21] = '{L, 4'h0, 3'd0, L, L, L, 8'h00, 8'h00, 8'h00, 8'h00, H, H, L, L, 8'h00}; // idle
        vecs[22] = '{H, 4'hA, 3'd0, L, L, L, 8'h00, 8'h00, 8'h00, 8'h01, L, L, L, L, 8'h00}; // RLF shifts carry in

        reset      = 1'b1;
        op_valid   = 1'b0;
        inst       = 4'h0;
        bit_number = 3'd0;
        switch_a_m = 1'b0;
        dest       = 1'b0;
        bus_en     = 1'b0;
        a          = 8'h00;
        f          = 8'h00;
        k          = 8'h00;
        #1;
        check_all_zero("reset0");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 23; i++)
            apply(vecs[i], i);

        // Load 0x5A with a write and bus drive pending, then reset mid-cycle
        apply('{H, 4'h8, 3'd0, L, H, L, 8'h00, 8'h5A, 8'h00, 8'h5A, L, L, H, L, 8'h00}, 100);
        apply('{L, 4'h0, 3'd0, L, L, H, 8'h00, 8'h00, 8'h00, 8'h5A, L, L, L, H, 8'h5A}, 101);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        op_valid = 1'b1;
        inst     = 4'h0;
        f        = 8'hFF;
        a        = 8'hFF;
        dest     = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        @(negedge clk);
        reset    = 1'b0;
        op_valid = 1'b0;
        dest     = 1'b0;
        bus_en   = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
